// File: rtl/ysyx_25040111_opimm_exu_pkg.sv
// Shared definitions for the OP-IMM execute unit: ALU op codes,
// FSM state encodings and small op-classification helpers.
package ysyx_25040111_opimm_exu_pkg;

    localparam int unsigned EXU_OP_W = 3;

    typedef logic [EXU_OP_W-1:0] exu_op_t;

    localparam exu_op_t EXU_ADD = 3'd0;
    localparam exu_op_t EXU_CMP = 3'd1;
    localparam exu_op_t EXU_AND = 3'd2;
    localparam exu_op_t EXU_OR  = 3'd3;
    localparam exu_op_t EXU_XOR = 3'd4;
    localparam exu_op_t EXU_LSH = 3'd5;
    localparam exu_op_t EXU_RSH = 3'd6;
    localparam exu_op_t EXU_RSV = 3'd7;

    localparam logic [1:0] EXU_ST_IDLE  = 2'd0;
    localparam logic [1:0] EXU_ST_SHIFT = 2'd1;
    localparam logic [1:0] EXU_ST_DONE  = 2'd2;

    function automatic logic exu_op_is_shift(input exu_op_t op);
        return (op == EXU_LSH) || (op == EXU_RSH);
    endfunction

    function automatic logic exu_op_is_valid(input exu_op_t op);
        return op != EXU_RSV;
    endfunction

endpackage

// File: rtl/ysyx_25040111_iter_shifter.sv
// Iterative shifter: shifts an accumulator by up to SHIFT_STEP bits per
// cycle until the loaded shift amount is exhausted.
module ysyx_25040111_iter_shifter
    import ysyx_25040111_opimm_exu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     start_i,
    input  logic                     left_i,
    input  logic                     arith_i,
    input  logic [XLEN-1:0]          operand_i,
    input  logic [$clog2(XLEN)-1:0]  shamt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [XLEN-1:0]          result_o
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] STEP_C = SHW'(SHIFT_STEP);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, arith_q;
    logic [SHW-1:0]  amt;

    // One shift step: min(cnt, SHIFT_STEP) bits in the latched direction
    always_comb begin
        amt   = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        acc_d = acc_q;
        if (left_q) begin
            acc_d = acc_q << amt;
        end else if (arith_q) begin
            acc_d = $unsigned($signed(acc_q) >>> amt);
        end else begin
            acc_d = acc_q >> amt;
        end
        cnt_d = cnt_q - amt;
    end

    assign busy_o   = (cnt_q != '0);
    assign done_o   = busy_o && (cnt_q <= STEP_C);
    assign result_o = acc_d;

    // Accumulator/count registers: load on start, step while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q   <= '0;
        end else if (start_i) begin
            acc_q   <= operand_i;
            cnt_q   <= shamt_i;
            left_q  <= left_i;
            arith_q <= arith_i;
        end else if (busy_o) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_25040111_opimm_exu.sv
// OP-IMM execute unit: single shared ALU for add/compare/logic ops,
// iterative shifter for slli/srli/srai, registered writeback output.
module ysyx_25040111_opimm_exu
    import ysyx_25040111_opimm_exu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXU_OP_W-1:0]  alu_op,
    input  logic                 cmp_signed,
    input  logic                 rsh_arith,
    input  logic [XLEN-1:0]      src1,
    input  logic [XLEN-1:0]      imm,
    input  logic [4:0]           rd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_wen
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_wen_q, out_wen_d;

    logic [XLEN-1:0] alu_result;
    logic [SHW-1:0]  shamt;
    logic            sh_start, sh_busy, sh_done;
    logic [XLEN-1:0] sh_result;

    assign shamt = imm[SHW-1:0];

    // Shared ALU; shift ops pass src1 through for the zero-shamt case
    always_comb begin
        alu_result = '0;
        case (alu_op)
            EXU_ADD: alu_result = src1 + imm;
            EXU_CMP: begin
                if (cmp_signed) alu_result = XLEN'($signed(src1) < $signed(imm));
                else            alu_result = XLEN'(src1 < imm);
            end
            EXU_AND: alu_result = src1 & imm;
            EXU_OR:  alu_result = src1 | imm;
            EXU_XOR: alu_result = src1 ^ imm;
            EXU_LSH: alu_result = src1;
            EXU_RSH: alu_result = src1;
            default: alu_result = '0;
        endcase
    end

    ysyx_25040111_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .start_i   (sh_start),
        .left_i    (alu_op == EXU_LSH),
        .arith_i   (rsh_arith),
        .operand_i (src1),
        .shamt_i   (shamt),
        .busy_o    (sh_busy),
        .done_o    (sh_done),
        .result_o  (sh_result)
    );

    // FSM next state and output register capture; flush beats accept and handshake
    always_comb begin
        state_d    = state_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        out_wen_d  = out_wen_q;
        sh_start   = 1'b0;
        if (flush) begin
            state_d = EXU_ST_IDLE;
        end else begin
            case (state_q)
                EXU_ST_IDLE: begin
                    if (in_valid) begin
                        out_rd_d  = rd;
                        out_wen_d = (rd != 5'd0) && exu_op_is_valid(alu_op);
                        if (exu_op_is_shift(alu_op) && (shamt != '0)) begin
                            sh_start = 1'b1;
                            state_d  = EXU_ST_SHIFT;
                        end else begin
                            out_data_d = alu_result;
                            state_d    = EXU_ST_DONE;
                        end
                    end
                end
                EXU_ST_SHIFT: begin
                    // Capture the final step's value on the same edge the count hits 0
                    if (sh_done || !sh_busy) begin
                        out_data_d = sh_result;
                        state_d    = EXU_ST_DONE;
                    end
                end
                EXU_ST_DONE: begin
                    if (out_ready) state_d = EXU_ST_IDLE;
                end
                default: state_d = EXU_ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EXU_ST_IDLE;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_wen_q  <= out_wen_d;
        end
    end

    assign in_ready  = (state_q == EXU_ST_IDLE);
    assign out_valid = (state_q == EXU_ST_DONE);
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign out_wen   = out_wen_q;

endmodule

// File: tb/tb_ysyx_25040111_opimm_exu.sv
// Self-checking bench for the OP-IMM execute unit against a behavioural model.
module tb_ysyx_25040111_opimm_exu;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic        cmp_signed;
    logic        rsh_arith;
    logic [31:0] src1;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040111_opimm_exu #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .cmp_signed(cmp_signed), .rsh_arith(rsh_arith),
        .src1(src1), .imm(imm), .rd(rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_wen(out_wen)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic cs,
                                               input logic ra, input logic [31:0] a,
                                               input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0: return a + b;
            3'd1: begin
                if (cs) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                return (a < b) ? 32'd1 : 32'd0;
            end
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: begin
                if (ra) return $unsigned($signed(a) >>> sh);
                return a >> sh;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
        if (op == 3'd5 || op == 3'd6) return 1 + (int'(b[4:0]) + STEP - 1) / STEP;
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL %s: in_ready stuck low, got %0b want 1", name, in_ready);
        end
    endtask

    // Issue one op, measure latency, optionally stall the output, then drain
    task automatic run_op(input logic [2:0] op, input logic cs, input logic ra,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                          input int hold, input string name);
        logic [31:0] exp_d;
        logic        exp_w;
        int          exp_lat, lat;
        exp_d   = ref_result(op, cs, ra, a, b);
        exp_w   = (r != 5'd0) && (op != 3'd7);
        exp_lat = ref_latency(op, b);
        wait_idle(name);
        in_valid = 1'b1; alu_op = op; cmp_signed = cs; rsh_arith = ra;
        src1 = a; imm = b; rd = r;
        step();
        in_valid = 1'b0;
        src1 = $urandom; imm = $urandom; rd = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (out_data !== exp_d || out_rd !== r || out_wen !== exp_w) begin
            errors++;
            $display("FAIL %s result: got data=%h rd=%0d wen=%0b want data=%h rd=%0d wen=%0b",
                     name, out_data, out_rd, out_wen, exp_d, r, exp_w);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            alu_op = 3'($urandom); src1 = $urandom; imm = $urandom; rd = 5'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_rd !== r) begin
                errors++;
                $display("FAIL %s stall %0d: got valid=%0b ready=%0b data=%h rd=%0d want 1 0 %h %0d",
                         name, i, out_valid, in_ready, out_data, out_rd, exp_d, r);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain: got valid=%0b ready=%0b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; cmp_signed = 1'b0; rsh_arith = 1'b0;
        src1 = '0; imm = '0; rd = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0 || out_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset: got ready=%0b valid=%0b rd=%0d data=%h wen=%0b want 1 0 0 0 0",
                     in_ready, out_valid, out_rd, out_data, out_wen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        run_op(3'd0, 1'b0, 1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 5'd3, 0, "addi");
        run_op(3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd4, 0, "slti");
        run_op(3'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd4, 0, "sltiu");
        run_op(3'd0, 1'b0, 1'b0, 32'h1111_1111, 32'h0000_0022, 5'd0, 0, "addi_rd0");
        run_op(3'd7, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 0, "reserved");
    endtask

    task automatic test_shift();
        run_op(3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'd31, 5'd7, 0, "srai31");
        run_op(3'd6, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 5'd7, 0, "srli31");
        run_op(3'd5, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 5'd8, 0, "slli0");
        run_op(3'd5, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FC1F, 5'd8, 0, "slli31_hiimm");
    endtask

    task automatic test_backpressure();
        run_op(3'd4, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0000_0FFF, 5'd12, 5, "backpressure");
    endtask

    task automatic test_flush();
        int seen = 0;
        wait_idle("flush");
        in_valid = 1'b1; alu_op = 3'd6; rsh_arith = 1'b0; src1 = 32'hFFFF_0000; imm = 32'd10; rd = 5'd5;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_shift: got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet: got %0d valid cycles want 0", seen);
        end
        in_valid = 1'b1; alu_op = 3'd0; src1 = 32'd1; imm = 32'd1; rd = 5'd1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept: got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
        run_op(3'd3, 1'b0, 1'b0, 32'h0F00_0000, 32'h0000_00F0, 5'd2, 0, "after_flush");
        in_valid = 1'b1; alu_op = 3'd0; src1 = 32'd7; imm = 32'd8; rd = 5'd6;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1; flush = 1'b1;
        step();
        out_ready = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midshift();
        wait_idle("rst_mid");
        in_valid = 1'b1; alu_op = 3'd5; src1 = 32'h0000_00FF; imm = 32'd20; rd = 5'd11;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'd0 || out_wen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got ready=%0b valid=%0b rd=%0d data=%h wen=%0b want 1 0 0 0 0",
                     in_ready, out_valid, out_rd, out_data, out_wen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(3'd6, 1'b0, 1'b1, 32'hF000_0000, 32'd3, 5'd13, 0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(7, 0)), 1'($urandom), 1'($urandom), $urandom, $urandom,
                   5'($urandom), int'($urandom_range(2, 0)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_backpressure();
        test_flush();
        test_reset_midshift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
